// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word, cache line and the L2 arbiter state.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } lc3b_arb_state;

endpackage

// File: rtl/l2_arbiter_control.sv
// Moore FSM that grants the single L2 port to the I- or D-cache, alternating
// between them when both ask in the same IDLE cycle.
module l2_arbiter_control
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_i,
  input  logic          d_req_i,
  input  logic          mem_resp_i,
  output lc3b_arb_state state_o,
  output logic          grant_i_o,
  output logic          grant_d_o
);

  lc3b_arb_state state_q, state_d;
  logic          last_d_q, last_d_d;  // 1: the most recent grant went to D

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    grant_i_o = 1'b0;
    grant_d_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_i && (!d_req_i || last_d_q)) begin
          grant_i_o = 1'b1;
          state_d   = I_BUSY;
          last_d_d  = 1'b0;
        end else if (d_req_i) begin
          grant_d_o = 1'b1;
          state_d   = D_BUSY;
          last_d_d  = 1'b1;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/l2_arbiter.sv
// Shares one L2 port between the I-cache and D-cache; request payload is
// captured at grant so the L2 sees stable address/data for the whole access.
module l2_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          i_mem_read,
  input  lc3b_word      i_mem_address,
  output logic          i_mem_resp,
  output lc3b_cacheline i_mem_rdata,
  input  logic          d_mem_read,
  input  logic          d_mem_write,
  input  lc3b_word      d_mem_address,
  input  lc3b_cacheline d_mem_wdata,
  output logic          d_mem_resp,
  output lc3b_cacheline d_mem_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output lc3b_word      mem_address,
  output lc3b_cacheline mem_wdata,
  input  logic          mem_resp,
  input  lc3b_cacheline mem_rdata
);

  lc3b_arb_state state;
  logic          grant_i, grant_d;
  lc3b_word      addr_q, addr_d;
  lc3b_cacheline wdata_q, wdata_d;
  logic          wr_q, wr_d;

  l2_arbiter_control u_control (
    .clk        (clk),
    .reset      (reset),
    .i_req_i    (i_mem_read),
    .d_req_i    (d_mem_read | d_mem_write),
    .mem_resp_i (mem_resp),
    .state_o    (state),
    .grant_i_o  (grant_i),
    .grant_d_o  (grant_d)
  );

  // A D request with both read and write raised is treated as a write-back.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    if (grant_i) begin
      addr_d = i_mem_address;
      wr_d   = 1'b0;
    end else if (grant_d) begin
      addr_d  = d_mem_address;
      wdata_d = d_mem_wdata;
      wr_d    = d_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;

  // Gating with reset keeps the L2 and cache strobes quiet in the very cycle
  // reset is raised, before the state register has been cleared.
  assign mem_read   = !reset && ((state == I_BUSY) || ((state == D_BUSY) && !wr_q));
  assign mem_write  = !reset && (state == D_BUSY) && wr_q;
  assign i_mem_resp = !reset && (state == I_BUSY) && mem_resp;
  assign d_mem_resp = !reset && (state == D_BUSY) && mem_resp;

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Randomized bench for l2_arbiter: a transaction-level arbitration model
// predicts each L2 access; a negedge monitor checks it against the L2 port.
module tb_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_mem_read;
  logic [15:0]  i_mem_address;
  logic         i_mem_resp;
  logic [127:0] i_mem_rdata;
  logic         d_mem_read, d_mem_write;
  logic [15:0]  d_mem_address;
  logic [127:0] d_mem_wdata;
  logic         d_mem_resp;
  logic [127:0] d_mem_rdata;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [127:0] mem_wdata;
  logic         mem_resp;
  logic [127:0] mem_rdata;

  l2_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .i_mem_read    (i_mem_read),
    .i_mem_address (i_mem_address),
    .i_mem_resp    (i_mem_resp),
    .i_mem_rdata   (i_mem_rdata),
    .d_mem_read    (d_mem_read),
    .d_mem_write   (d_mem_write),
    .d_mem_address (d_mem_address),
    .d_mem_wdata   (d_mem_wdata),
    .d_mem_resp    (d_mem_resp),
    .d_mem_rdata   (d_mem_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_resp      (mem_resp),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_d;
    bit           wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: at each edge an idle port serves the pending requester; on a
  // tie the one that was not served last wins. The access ends on mem_resp.
  bit m_busy;
  bit m_last_d;
  initial begin
    txn_t t;
    bit ireq, dreq, pick_d;
    m_busy   = 1'b0;
    m_last_d = 1'b1;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_busy   = 1'b0;
        m_last_d = 1'b1;
        exp_q.delete();
      end else if (m_busy) begin
        if (mem_resp) m_busy = 1'b0;
      end else begin
        ireq = i_mem_read;
        dreq = d_mem_read | d_mem_write;
        if (ireq || dreq) begin
          pick_d  = dreq && (!ireq || !m_last_d);
          t.is_d  = pick_d;
          t.wr    = pick_d && d_mem_write;
          t.addr  = pick_d ? d_mem_address : i_mem_address;
          t.wdata = pick_d ? d_mem_wdata : '0;
          exp_q.push_back(t);
          m_last_d = pick_d;
          m_busy   = 1'b1;
        end
      end
    end
  end

  // Stimulus (caches + L2 model) and monitor, all on the falling edge.
  initial begin
    txn_t cur;
    bit   have_cur, prev_active, active, i_out, d_out;
    int   l2_cnt;
    have_cur = 0; prev_active = 0; i_out = 0; d_out = 0; l2_cnt = -1;
    reset = 1'b1;
    i_mem_read = 0; i_mem_address = '0;
    d_mem_read = 0; d_mem_write = 0; d_mem_address = '0; d_mem_wdata = '0;
    mem_resp = 0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_resp", i_mem_resp, 0);
    chk("rst_d_resp", d_mem_resp, 0);
    chk("rst_mem_address", mem_address, 0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 300 == 250) begin
        for (int k = 0; k < 2; k++) begin
          if (k > 0) @(negedge clk);
          reset = 1'b1;
          mem_resp = 1'($urandom % 2);
          i_mem_read = 0; d_mem_read = 0; d_mem_write = 0;
          i_out = 0; d_out = 0;
          #1;
          chk("reset_mem_rw", {mem_read, mem_write}, 0);
          chk("reset_resp", {i_mem_resp, d_mem_resp}, 0);
          if (k == 1) chk("reset_payload", mem_address, 0);
        end
        prev_active = 0; have_cur = 0; l2_cnt = -1;
        continue;
      end

      reset  = 1'b0;
      active = mem_read | mem_write;
      if (active) begin
        if (l2_cnt < 0) l2_cnt = $urandom_range(0, 3);
        if (l2_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = {$urandom, $urandom, $urandom, $urandom};
          l2_cnt    = -1;
        end else begin
          mem_resp = 1'b0;
          l2_cnt--;
        end
      end else begin
        mem_resp  = ($urandom % 6 == 0);  // stray L2 response while idle
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        l2_cnt    = -1;
      end
      #1;

      if (active && !prev_active) begin
        have_cur = 0;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL grant_start: L2 access began (addr %0h), none expected (t=%0t)", mem_address, $time);
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
        end
      end
      if (!active) begin
        chk("grant_latency", exp_q.size(), 0);
        exp_q.delete();
        chk("idle_mem_rw", {mem_read, mem_write}, 0);
        chk("idle_resp", {i_mem_resp, d_mem_resp}, 0);
      end else if (have_cur) begin
        chk("mem_read", mem_read, !cur.wr);
        chk("mem_write", mem_write, cur.wr);
        chk("mem_address", mem_address, cur.addr);
        if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
        chk("i_mem_resp", i_mem_resp, mem_resp && !cur.is_d);
        chk("d_mem_resp", d_mem_resp, mem_resp && cur.is_d);
        if (mem_resp) begin
          $display("txn %s %s addr=%04h", cur.is_d ? "D" : "I", cur.wr ? "WR" : "RD", cur.addr);
          if (cur.is_d) chk("d_mem_rdata", d_mem_rdata, mem_rdata);
          else          chk("i_mem_rdata", i_mem_rdata, mem_rdata);
        end
      end
      prev_active = active;

      if (i_mem_resp) begin
        i_out = 0; i_mem_read = 0;
      end else if (!i_out) begin
        if ($urandom % 2 == 0) begin
          i_out = 1; i_mem_read = 1; i_mem_address = 16'($urandom);
        end
      end else if ($urandom % 4 == 0) begin
        i_mem_address = 16'($urandom);
      end

      if (d_mem_resp) begin
        d_out = 0; d_mem_read = 0; d_mem_write = 0;
      end else if (!d_out) begin
        if ($urandom % 2 == 0) begin
          d_out = 1;
          case ($urandom % 3)
            0:       begin d_mem_read = 1; d_mem_write = 0; end
            1:       begin d_mem_read = 0; d_mem_write = 1; end
            default: begin d_mem_read = 1; d_mem_write = 1; end
          endcase
          d_mem_address = 16'($urandom);
          d_mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom % 3 == 0) begin
        d_mem_address = 16'($urandom);
        d_mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 The block SHALL have port: clk  input  1  system clock; all state updates on its rising edge.
REQ-002 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have port: i_mem_read  input  1  I-cache miss read request.
REQ-004 The block SHALL have port: i_mem_address  input  lc3b_word  I-cache line address.
REQ-005 The block SHALL have port: i_mem_resp  output  1  I-cache request complete.
REQ-006 The block SHALL have port: i_mem_rdata  output  lc3b_cacheline  line returned to I-cache.
REQ-007 The block SHALL have port: d_mem_read, d_mem_write  input  1 each  D-cache read or write-back request.
REQ-008 The block SHALL have port: d_mem_address  input  lc3b_word  D-cache line address.
REQ-009 The block SHALL have port: d_mem_wdata  input  lc3b_cacheline  D-cache write-back line.
REQ-010 The block SHALL have port: d_mem_resp  output  1  D-cache request complete.
REQ-011 The block SHALL have port: d_mem_rdata  output  lc3b_cacheline  line returned to D-cache.
REQ-012 The block SHALL have port: mem_read, mem_write  output  1 each  request to L2 cache.
REQ-013 The block SHALL have port: mem_address  output  lc3b_word  and  mem_wdata  output  lc3b_cacheline  L2 request payload.
REQ-014 The block SHALL have port: mem_resp  input  1  and  mem_rdata  input  lc3b_cacheline  L2 completion and read line.
REQ-015 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-016 The control SHALL be a Moore FSM with states IDLE, I_BUSY and D_BUSY.
REQ-017 In IDLE with exactly one requester active, the FSM SHALL enter that requester's BUSY state on the next edge.
REQ-018 In IDLE with both requesters active, the grant SHALL go to the requester not recorded in last_grant (round-robin); last_grant SHALL update on every grant.
REQ-019 On grant, the granted address, the write data (D only) and the op (read/write) SHALL be latched into payload registers; mem_address/mem_wdata SHALL be driven only from these registers and SHALL stay stable for the whole BUSY state.
REQ-020 mem_read SHALL be 1 in I_BUSY and in D_BUSY for a D read; mem_write SHALL be 1 only in D_BUSY for a D write; both SHALL be 0 in IDLE; they SHALL never be 1 together.
REQ-021 If d_mem_read and d_mem_write are sampled together at grant, the op SHALL be latched as write.
REQ-022 In a BUSY state, mem_resp=1 SHALL assert the granted requester's resp combinationally in the same cycle and SHALL move the FSM to IDLE on the next edge; the other resp SHALL stay 0.
REQ-023 i_mem_rdata and d_mem_rdata SHALL both equal mem_rdata combinationally; only resp qualifies them.
REQ-024 Latency: request sampled at edge N SHALL produce mem_read/mem_write from cycle N+1; minimum request-to-resp = 1 + L2 latency.
REQ-025 The cycle after a resp the FSM SHALL be in IDLE, where a new request (including the other pending requester) SHALL be granted at the following edge; back-to-back service SHALL therefore have exactly one IDLE cycle between BUSY states.
REQ-026 Requests arriving or changing while BUSY SHALL be ignored until IDLE; mem_resp in IDLE SHALL be ignored.

Reset
REQ-027 On reset the FSM SHALL enter IDLE, last_grant SHALL become D, and payload registers SHALL clear to 0.
REQ-028 During and after reset, mem_read, mem_write, i_mem_resp and d_mem_resp SHALL be 0; reset mid-transaction SHALL abort it with no resp issued.

Structure
REQ-029 The enum lc3b_arb_state {IDLE, I_BUSY, D_BUSY} SHALL be placed in lc3b_types; lc3b_word and lc3b_cacheline SHALL come from lc3b_types.
REQ-030 The FSM and the round-robin logic SHALL live in one sub-module, l2_arbiter_control; payload registers and muxes SHALL stay in l2_arbiter.

Verification
REQ-031 Scenario: I read only, address 0x1230, L2 responds 3 cycles later with line L -> mem_read=1 and mem_address=0x1230 from cycle N+1; i_mem_resp=1 with i_mem_rdata=L for 1 cycle; d_mem_resp=0.
REQ-032 Scenario: D write, address 0x4560, wdata W -> mem_write=1, mem_read=0, mem_wdata=W; d_mem_resp on mem_resp.
REQ-033 Scenario: after reset, I and D both request in the same cycle -> I granted first (last_grant=D); D granted after one IDLE cycle; next collision -> I again.
REQ-034 Scenario: d_mem_address changes from 0x4560 to 0x7770 while D_BUSY -> mem_address holds 0x4560 until resp.
REQ-035 Scenario: reset asserted in I_BUSY -> next cycle IDLE, mem_read=0, no i_mem_resp; mem_resp pulsed in IDLE -> no resp.
